// File: rtl/gpio_input_capture.sv
// Multi-channel GPIO input capture: synchronise, optionally glitch-filter, edge-detect, sticky-capture, interrupt.
// Unfiltered capture sets SYNC_STAGES+1 edges after a pin change; filtered adds FILTER_DEPTH sample ticks.
module gpio_input_capture #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_DEPTH = 4,
  parameter int PRESCALE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      en_noise_cancelling,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [2*WIDTH-1:0]    select_edge,
  input  logic [2*WIDTH-1:0]    select_interrupt,
  input  logic [WIDTH-1:0]      interrupt_mask,
  input  logic [WIDTH-1:0]      clr,
  output logic [WIDTH-1:0]      data_out,
  output logic [WIDTH-1:0]      capture,
  output logic [WIDTH-1:0]      irq_vec,
  output logic                  irq
);
  localparam int FCNT_W = (FILTER_DEPTH > 2) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_DEPTH - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][FCNT_W-1:0]      fcnt_q;
  logic [PRESCALE_W-1:0]             pcnt_q;
  logic [WIDTH-1:0] sync_lvl, filt_q, prev_q, ncn_q, level, rise, fall, hit;
  logic             tick;

  // The synchroniser is never frozen so the pin view stays current across enable changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign tick     = enable && (pcnt_q >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else if (enable) begin
      pcnt_q <= tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_lvl[i] != filt_q[i]) begin
          if (fcnt_q[i] == FCNT_LAST) begin
            filt_q[i] <= sync_lvl[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  assign level    = (en_noise_cancelling & filt_q) | (~en_noise_cancelling & sync_lvl);
  assign data_out = level;
  assign rise     = level & ~prev_q;
  assign fall     = ~level & prev_q;

  // A mode switch can flip the level without any pin activity, so that cycle's edge is dropped.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = (en_noise_cancelling[i] == ncn_q[i]) &&
               ((rise[i] && select_edge[2*i]) || (fall[i] && select_edge[2*i+1]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncn_q   <= '0;
      prev_q  <= '0;
      capture <= '0;
    end else begin
      ncn_q   <= en_noise_cancelling;
      if (enable) prev_q <= level;
      capture <= (capture & ~clr) | (enable ? hit : '0);
    end
  end

  always_comb begin
    irq_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (select_interrupt[2*i +: 2])
        2'b01:   irq_vec[i] = interrupt_mask[i] & capture[i];
        2'b10:   irq_vec[i] = interrupt_mask[i] & level[i];
        2'b11:   irq_vec[i] = interrupt_mask[i] & ~level[i];
        default: irq_vec[i] = 1'b0;
      endcase
    end
  end

  assign irq = |irq_vec;
endmodule

// File: tb/tb_gpio_input_capture.sv
// Bench for gpio_input_capture: fixed table, directed corner sequences, then random traffic vs a reference model.
module tb_gpio_input_capture;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  en_noise_cancelling = '0;
  logic [15:0]   prescale = '0;
  logic [2*W-1:0] select_edge = '0;
  logic [2*W-1:0] select_interrupt = '0;
  logic [W-1:0]  interrupt_mask = '0;
  logic [W-1:0]  clr = '0;
  logic [W-1:0]  data_out, capture, irq_vec;
  logic          irq;

  int tests = 0;
  int fails = 0;

  gpio_input_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .en_noise_cancelling(en_noise_cancelling), .prescale(prescale),
    .select_edge(select_edge), .select_interrupt(select_interrupt),
    .interrupt_mask(interrupt_mask), .clr(clr), .data_out(data_out),
    .capture(capture), .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: pin history, tick counter, per-channel run lengths and sticky flags.
  logic [W-1:0] m_sync [SS];
  logic [W-1:0] m_filt, m_prev, m_ncn_prev, m_cap;
  int           m_pcnt;
  int           m_run [W];

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    m_filt = '0; m_prev = '0; m_ncn_prev = '0; m_cap = '0; m_pcnt = 0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  function automatic logic [W-1:0] m_level();
    return (en_noise_cancelling & m_filt) | (~en_noise_cancelling & m_sync[SS-1]);
  endfunction

  function automatic logic [W-1:0] m_irq_vec();
    logic [W-1:0] lvl, v;
    lvl = m_level();
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (select_interrupt[2*i +: 2] == 2'd1) v[i] = m_cap[i];
      else if (select_interrupt[2*i +: 2] == 2'd2) v[i] = lvl[i];
      else if (select_interrupt[2*i +: 2] == 2'd3) v[i] = !lvl[i];
      v[i] = v[i] && interrupt_mask[i];
    end
    return v;
  endfunction

  task automatic model_edge();
    logic [W-1:0] lvl;
    bit tick, same_mode, r, f, hit;
    lvl  = m_level();
    tick = enable && (m_pcnt >= int'(prescale));
    for (int i = 0; i < W; i++) begin
      same_mode = (en_noise_cancelling[i] == m_ncn_prev[i]);
      r = lvl[i] && !m_prev[i];
      f = !lvl[i] && m_prev[i];
      hit = same_mode && ((r && select_edge[2*i]) || (f && select_edge[2*i+1]));
      m_cap[i] = (enable && hit) || (m_cap[i] && !clr[i]);
      if (tick) begin
        if (m_sync[SS-1][i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == FD) begin
            m_filt[i] = m_sync[SS-1][i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (enable) begin
      m_prev = lvl;
      m_pcnt = tick ? 0 : m_pcnt + 1;
    end
    m_ncn_prev = en_noise_cancelling;
    for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = data_in;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_level()));
    chk({tag, ".capture"},  32'(capture),  32'(m_cap));
    chk({tag, ".irq_vec"},  32'(irq_vec),  32'(m_irq_vec()));
    chk({tag, ".irq"},      32'(irq),      32'(|m_irq_vec()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    step("rst");
    step("rst");
    rst = 1'b0;
  endtask

  typedef struct {
    logic d;
    logic c;
    logic exp_dout;
    logic exp_cap;
    logic exp_irq;
  } vec_t;
  vec_t tbl [11];

  int ncap;

  initial begin
    // Channel 0 unfiltered rising-edge capture, clear and set-beats-clear.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset with pins held high.
    data_in = 8'hFF; select_edge = 16'h5555;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_cap",  32'(capture),  32'h0);
    chk("rst_irq",  32'(irq),      32'h0);
    step("rst"); step("rst");
    chk("rst_hold_dout", 32'(data_out), 32'h0);
    rst = 1'b0;
    step("rel1");
    step("rel2");
    chk("rel2_cap",  32'(capture),  32'h0);
    chk("rel2_dout", 32'(data_out), 32'hFF);
    step("rel3");
    chk("rel3_cap",  32'(capture),  32'hFF);

    // Table-driven channel 0 sequence.
    data_in = '0; select_edge = 16'h0001; select_interrupt = 16'h0001; interrupt_mask = 8'h01;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      data_in[0] = tbl[k].d;
      clr[0]     = tbl[k].c;
      step("tbl");
      chk($sformatf("tbl%0d_dout", k), 32'(data_out[0]), 32'(tbl[k].exp_dout));
      chk($sformatf("tbl%0d_cap", k),  32'(capture[0]),  32'(tbl[k].exp_cap));
      chk($sformatf("tbl%0d_irq", k),  32'(irq),         32'(tbl[k].exp_irq));
    end
    clr = '0;

    // Channel 1 filtered: short pulse rejected, sustained level accepted.
    data_in = '0; en_noise_cancelling = 8'h02; select_edge = 16'h0004;
    select_interrupt = '0; interrupt_mask = '0; prescale = '0;
    do_reset();
    data_in[1] = 1'b1; step("pulse"); step("pulse");
    data_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step("pulse");
      chk("pulse_dout1", 32'(data_out[1]), 32'h0);
      chk("pulse_cap1",  32'(capture[1]),  32'h0);
    end
    data_in[1] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step("filt");
      if (e == 5) chk("filt_e5_dout1", 32'(data_out[1]), 32'h0);
      if (e == 6) chk("filt_e6_dout1", 32'(data_out[1]), 32'h1);
      if (e == 6) chk("filt_e6_cap1",  32'(capture[1]),  32'h0);
      if (e == 7) chk("filt_e7_cap1",  32'(capture[1]),  32'h1);
    end

    // Channel 2 both-edge, filtered, ticks every 4th cycle.
    data_in = '0; en_noise_cancelling = 8'h04; select_edge = 16'h0030; prescale = 16'd3;
    do_reset();
    data_in[2] = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step("both");
      if (e == 15) chk("both_e15_dout2", 32'(data_out[2]), 32'h0);
      if (e == 16) chk("both_e16_dout2", 32'(data_out[2]), 32'h1);
      if (e == 17) chk("both_e17_cap2",  32'(capture[2]),  32'h1);
    end
    clr[2] = 1'b1; step("both"); clr = '0;
    data_in[2] = 1'b0;
    ncap = 0;
    for (int k = 0; k < 24; k++) begin
      step("both_fall");
      clr = '0;
      if (capture[2]) begin
        ncap++;
        clr[2] = 1'b1;
      end
    end
    clr = '0;
    chk("both_fall_captures", 32'(ncap), 32'd1);
    chk("both_fall_dout2", 32'(data_out[2]), 32'h0);

    // Level interrupt modes and mode-switch edge suppression.
    data_in = '0; en_noise_cancelling = '0; select_edge = 16'h0300;
    select_interrupt = 16'h00C0; interrupt_mask = 8'h08; prescale = 16'd200;
    do_reset();
    step("lvl");
    chk("lvl_low_irq", 32'(irq), 32'h1);
    interrupt_mask = '0;
    #1;
    check_all("mask0");
    chk("mask0_irq", 32'(irq), 32'h0);
    data_in[4] = 1'b1;
    for (int k = 0; k < 4; k++) step("ncn");
    chk("ncn_rise_cap4", 32'(capture[4]), 32'h1);
    clr[4] = 1'b1; step("ncn"); clr = '0; step("ncn");
    chk("ncn_clr_cap4", 32'(capture[4]), 32'h0);
    en_noise_cancelling[4] = 1'b1;
    for (int k = 0; k < 4; k++) step("ncn_on");
    chk("ncn_on_cap4", 32'(capture[4]), 32'h0);
    chk("ncn_on_dout4", 32'(data_out[4]), 32'h0);
    en_noise_cancelling[4] = 1'b0;
    for (int k = 0; k < 4; k++) step("ncn_off");
    chk("ncn_off_cap4", 32'(capture[4]), 32'h0);

    // enable=0 freezes capture sets and filters; clr still acts.
    data_in = '0; en_noise_cancelling = 8'h40; select_edge = 16'h0C00;
    select_interrupt = '0; prescale = '0;
    do_reset();
    data_in[5] = 1'b1;
    for (int k = 0; k < 3; k++) step("en");
    chk("en_cap5", 32'(capture[5]), 32'h1);
    enable = 1'b0; data_in[5] = 1'b0; data_in[6] = 1'b1;
    for (int k = 0; k < 4; k++) step("dis");
    data_in[5] = 1'b1;
    for (int k = 0; k < 4; k++) step("dis");
    chk("dis_hold_cap5", 32'(capture[5]), 32'h1);
    chk("dis_frozen_dout6", 32'(data_out[6]), 32'h0);
    clr[5] = 1'b1; step("dis_clr"); clr = '0;
    chk("dis_clr_cap5", 32'(capture[5]), 32'h0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) step("reen");
    chk("reen_quiet_cap5", 32'(capture[5]), 32'h0);
    data_in[5] = 1'b0;
    for (int k = 0; k < 3; k++) step("reen");
    chk("reen_edge_cap5", 32'(capture[5]), 32'h1);

    // Random traffic against the model.
    data_in = '0; en_noise_cancelling = '0; prescale = '0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      data_in ^= W'($urandom & $urandom & $urandom);
      clr      = W'($urandom & $urandom & $urandom);
      enable   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) en_noise_cancelling ^= W'($urandom);
      if ($urandom_range(0, 199) == 0) prescale = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        select_edge      = 16'($urandom);
        select_interrupt = 16'($urandom);
        interrupt_mask   = W'($urandom);
      end
      #1;
      check_all("rnd_comb");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
